// File: rtl/disp7seg_pkg.sv
// Shared glyph table and sizing helpers for the multiplexed 7-segment driver.
// Glyphs are active-low {g,f,e,d,c,b,a}; the top applies polarity at the pins.
package disp7seg_pkg;

    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/disp7seg_scan_glyph.sv
// Nibble to active-low segment pattern; 10..15 go dark unless hex mode is on.
module hex7seg_glyph
    import disp7seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    input  logic       suppress,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        if (!suppress) begin
            case (nibble)
                4'h0: seg_n = GLYPH_0;
                4'h1: seg_n = GLYPH_1;
                4'h2: seg_n = GLYPH_2;
                4'h3: seg_n = GLYPH_3;
                4'h4: seg_n = GLYPH_4;
                4'h5: seg_n = GLYPH_5;
                4'h6: seg_n = GLYPH_6;
                4'h7: seg_n = GLYPH_7;
                4'h8: seg_n = GLYPH_8;
                4'h9: seg_n = GLYPH_9;
                4'hA: seg_n = hex_mode ? GLYPH_A : SEG_BLANK;
                4'hB: seg_n = hex_mode ? GLYPH_B : SEG_BLANK;
                4'hC: seg_n = hex_mode ? GLYPH_C : SEG_BLANK;
                4'hD: seg_n = hex_mode ? GLYPH_D : SEG_BLANK;
                4'hE: seg_n = hex_mode ? GLYPH_E : SEG_BLANK;
                4'hF: seg_n = hex_mode ? GLYPH_F : SEG_BLANK;
                default: seg_n = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/disp7seg_scan.sv
// Time-multiplexed N-digit 7-segment driver with shadow capture, leading-zero
// suppression, per-digit DP, global blanking and a dark gap at each slot start.
module disp7seg_scan
    import disp7seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GAP         = 2,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [4*NUM_DIGITS-1:0] VALUE,
    input  logic                    LOAD,
    input  logic [NUM_DIGITS-1:0]   DP_IN,
    input  logic                    HEX_MODE,
    input  logic                    LZ_SUPPRESS,
    input  logic                    BLANK,
    output logic [6:0]              SEG,
    output logic                    DP,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    SCAN_DONE
);

    localparam int IW = idx_width(NUM_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0]         LAST_CNT = CW'(REFRESH_DIV - 1);
    localparam logic [6:0]            SEG_OFF  = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF   = (SEG_ACT_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACT_LOW != 0}};

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [NUM_DIGITS-1:0]   shadow_dp;

    logic                  wrap;
    logic [3:0]            nibble;
    logic                  dp_req;
    logic                  lz_blank;
    logic                  an_on;
    logic [NUM_DIGITS-1:0] an_sel;
    logic [6:0]            glyph_n;

    assign wrap  = (cnt == LAST_CNT);
    assign an_on = !BLANK && (int'(cnt) >= GAP);

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        nibble   = 4'd0;
        dp_req   = 1'b0;
        an_sel   = '0;
        lz_blank = (idx != '0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k == int'(idx)) begin
                nibble    = shadow[4*k +: 4];
                dp_req    = shadow_dp[k];
                an_sel[k] = 1'b1;
            end
            if (k >= int'(idx) && shadow[4*k +: 4] != 4'd0)
                lz_blank = 1'b0;
        end
    end

    hex7seg_glyph u_glyph (
        .nibble   (nibble),
        .hex_mode (HEX_MODE),
        .suppress (LZ_SUPPRESS && lz_blank),
        .seg_n    (glyph_n)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt       <= '0;
            idx       <= '0;
            shadow    <= '0;
            shadow_dp <= '0;
            SEG       <= SEG_OFF;
            DP        <= DP_OFF;
            AN        <= AN_OFF;
            SCAN_DONE <= 1'b0;
        end else begin
            if (LOAD) begin
                shadow    <= VALUE;
                shadow_dp <= DP_IN;
            end
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap)
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            SEG       <= (SEG_ACT_LOW != 0) ? glyph_n : ~glyph_n;
            DP        <= (SEG_ACT_LOW != 0) ? ~dp_req : dp_req;
            AN        <= !an_on ? AN_OFF : ((AN_ACT_LOW != 0) ? ~an_sel : an_sel);
            SCAN_DONE <= wrap && (idx == LAST_IDX);
        end
    end

endmodule
